// File: rtl/fetch_queue.sv
// Instruction fetch buffer: circular FIFO of {pc, instr} between fetch and decode.
// Optional zero-latency pass-through when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_pc4,
  output logic [31:0]       out_instr,
  input  logic              dec_ready,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic full;
  logic empty;
  logic stored_valid;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // rst masks the outputs so they read as idle even before the first reset edge.
  assign stored_valid = !rst && !empty;
  assign in_ready     = rst || !full;
  assign level        = rst ? '0 : count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty && !flush && !rst;

  always_comb begin
    out_valid = stored_valid;
    out_pc    = '0;
    out_instr = '0;
    if (bypass) begin
      out_valid = in_valid;
      if (in_valid) begin
        out_pc    = in_pc;
        out_instr = in_instr;
      end
    end else if (stored_valid) begin
      out_pc    = pc_q[rd_ptr];
      out_instr = instr_q[rd_ptr];
    end
  end

  // A pass-through consumed by decode is never written into the queue.
  assign push = in_valid && in_ready && !flush && !(bypass && dec_ready);
`else
  always_comb begin
    out_valid = stored_valid;
    out_pc    = '0;
    out_instr = '0;
    if (stored_valid) begin
      out_pc    = pc_q[rd_ptr];
      out_instr = instr_q[rd_ptr];
    end
  end

  assign push = in_valid && in_ready && !flush;
`endif

  assign pop     = stored_valid && dec_ready && !flush;
  assign out_pc4 = out_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_q[wr_ptr]    <= in_pc;
      instr_q[wr_ptr] <= in_instr;
    end
  end

endmodule
